// File: rtl/replica_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : replica_pkg
//  Description : Shared types for the replica-exchange datapath: the opt
//                pairing command encoding and the round scheduler states.
//  Revision    : 1.0 - initial release
// ============================================================================
package replica_pkg;

    // Pairing command to the opt unit: even pairs (OR0) or odd pairs (OR1)
    typedef enum logic [0:0] {
        OR0 = 1'b0,
        OR1 = 1'b1
    } opt_cmd_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXP_INIT = 3'd1,
        EXP_RUN  = 3'd2,
        TEST     = 3'd3,
        SHIFT    = 3'd4,
        DONE     = 3'd5
    } sched_state_t;

    // Bits needed to count 0 .. max(a,b)-1
    function automatic int phase_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/replica_popcnt.sv
`default_nettype none
// ============================================================================
//  Module      : replica_popcnt
//  Description : Population count of an N-bit vector; used only when
//                EXCHANGE_STAT_EN is defined in the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module replica_popcnt #(
    parameter int N = 32
) (
    input  logic [N-1:0]             vec,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/replica_exchange_sched.sv
`default_nettype none
// ============================================================================
//  Module      : replica_exchange_sched
//  Description : Round scheduler for the replica-exchange phase: sequences
//                exp init/run, the exchange test strobe and the shift window.
//                Optional EXCHANGE_STAT_EN adds an accepted-pair counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module replica_exchange_sched
    import replica_pkg::*;
#(
    parameter int replica_num = 32,
    parameter int EXP_CYCLES  = 17,
    parameter int ROUND_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ROUND_W-1:0] rounds,
`ifdef EXCHANGE_STAT_EN
    input  logic [replica_num-1:0] exchange_vec,
    output logic [31:0]        xchg_cnt,
`endif
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               exp_init,
    output logic               exp_run,
    output logic               exchange_run,
    output logic               exchange_shift_d,
    output opt_cmd_t           opt_command,
    output logic [ROUND_W-1:0] round_cnt
);

    localparam int PH_W = phase_width(EXP_CYCLES, replica_num);

    sched_state_t       state;
    sched_state_t       next_state;
    logic [PH_W-1:0]    phase;
    logic [ROUND_W-1:0] rounds_q;
    logic [ROUND_W-1:0] rc_next;
    logic               accept;
    logic               exp_last;
    logic               round_end;

    assign accept    = start && ready && !abort;
    assign exp_last  = (state == EXP_RUN) && (phase == PH_W'(EXP_CYCLES - 1));
    assign round_end = (state == SHIFT) && (phase == PH_W'(replica_num - 1));
    assign rc_next   = round_cnt + ROUND_W'(1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = (rounds == '0) ? DONE : EXP_INIT;
            EXP_INIT: next_state = EXP_RUN;
            EXP_RUN:  if (exp_last) next_state = TEST;
            TEST:     next_state = SHIFT;
            SHIFT:    if (round_end) next_state = (rc_next == rounds_q) ? DONE : EXP_INIT;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Strobes are decoded from next_state so each flop is high exactly in its state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready            <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            exp_init         <= 1'b0;
            exp_run          <= 1'b0;
            exchange_run     <= 1'b0;
            exchange_shift_d <= 1'b0;
        end else begin
            ready            <= (next_state == IDLE);
            busy             <= (next_state != IDLE);
            done             <= (next_state == DONE);
            exp_init         <= (next_state == EXP_INIT);
            exp_run          <= (next_state == EXP_RUN);
            exchange_run     <= (next_state == TEST);
            exchange_shift_d <= (next_state == SHIFT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (next_state != state) begin
            phase <= '0;
        end else if (state == EXP_RUN || state == SHIFT) begin
            phase <= phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rounds_q    <= '0;
            round_cnt   <= '0;
            opt_command <= OR0;
        end else if (accept) begin
            rounds_q    <= rounds;
            round_cnt   <= '0;
            opt_command <= OR0;
        end else if (round_end && !abort) begin
            round_cnt   <= rc_next;
            opt_command <= (opt_command == OR0) ? OR1 : OR0;
        end
    end

`ifdef EXCHANGE_STAT_EN
    localparam int PC_W = $clog2(replica_num + 1);

    logic [PC_W-1:0] pop;
    logic [32:0]     xchg_sum;

    replica_popcnt #(
        .N (replica_num)
    ) u_popcnt (
        .vec   (exchange_vec),
        .count (pop)
    );

    // Each accepted exchange flags both partners, hence the halving
    assign xchg_sum = {1'b0, xchg_cnt} + 33'(pop >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xchg_cnt <= '0;
        end else if (accept) begin
            xchg_cnt <= '0;
        end else if (state == SHIFT && phase == '0) begin
            xchg_cnt <= xchg_sum[32] ? 32'hFFFF_FFFF : xchg_sum[31:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_replica_exchange_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_replica_exchange_sched
//  Description : Self-checking bench for replica_exchange_sched (4 replicas,
//                3 exp cycles); EXCHANGE_STAT_EN also checks xchg_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_replica_exchange_sched;
    import replica_pkg::*;

    localparam int RN = 4;
    localparam int EC = 3;
    localparam int RW = 16;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [RW-1:0] rounds = '0;
    logic          ready, busy, done, exp_init, exp_run, exchange_run, exchange_shift_d;
    opt_cmd_t      opt_command;
    logic [RW-1:0] round_cnt;
`ifdef EXCHANGE_STAT_EN
    logic [RN-1:0] exchange_vec = 4'b0110;
    logic [31:0]   xchg_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          start;
        logic          abort;
        logic [RW-1:0] rounds;
        logic          ready, busy, done, ei, er, xr, xs, opt;
        logic [RW-1:0] rc;
    } vec_t;

    vec_t tbl[32];
    int   tbl_n;
    vec_t sb_q[$];

    replica_exchange_sched #(
        .replica_num (RN),
        .EXP_CYCLES  (EC),
        .ROUND_W     (RW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .rounds           (rounds),
`ifdef EXCHANGE_STAT_EN
        .exchange_vec     (exchange_vec),
        .xchg_cnt         (xchg_cnt),
`endif
        .ready            (ready),
        .busy             (busy),
        .done             (done),
        .exp_init         (exp_init),
        .exp_run          (exp_run),
        .exchange_run     (exchange_run),
        .exchange_shift_d (exchange_shift_d),
        .opt_command      (opt_command),
        .round_cnt        (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs in cycle n of a rounds=2 run started in cycle 0
    function automatic vec_t golden(input int n);
        vec_t v;
        v.start  = 1'b0;
        v.abort  = 1'b0;
        v.rounds = 16'd2;
        v.ready  = (n >= 20);
        v.busy   = (n < 20);
        v.done   = (n == 19);
        v.ei     = (n == 1) || (n == 10);
        v.er     = (n >= 2 && n <= 4) || (n >= 11 && n <= 13);
        v.xr     = (n == 5) || (n == 14);
        v.xs     = (n >= 6 && n <= 9) || (n >= 15 && n <= 18);
        v.opt    = (n >= 10 && n <= 18);
        v.rc     = (n <= 9) ? 16'd0 : (n <= 18) ? 16'd1 : 16'd2;
        return v;
    endfunction

    function automatic vec_t idle_rec(input logic st, input logic ab, input logic [RW-1:0] rd,
                                      input logic opt, input logic [RW-1:0] rc);
        vec_t v;
        v.start = st;  v.abort = ab;  v.rounds = rd;
        v.ready = 1'b1; v.busy = 1'b0; v.done = 1'b0;
        v.ei = 1'b0; v.er = 1'b0; v.xr = 1'b0; v.xs = 1'b0;
        v.opt = opt;  v.rc = rc;
        return v;
    endfunction

    task automatic build_run(input int pulse, input int n);
        for (int i = 0; i < n; i++) begin
            tbl[i]       = golden(i + 1);
            tbl[i].start = (i == 0) || (i == pulse);
        end
        tbl_n = n;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_strobes"}, 32'({exp_init, exp_run, exchange_run, exchange_shift_d}), 32'd0);
        chk({tag, "_opt"},   32'(opt_command), 32'(OR0));
        chk({tag, "_rc"},    32'(round_cnt), 32'd0);
`ifdef EXCHANGE_STAT_EN
        chk({tag, "_xchg"},  xchg_cnt, 32'd0);
`endif
    endtask

    // Record i: inputs driven in cycle i, outputs expected in cycle i+1
    task automatic apply_table(input string tag);
        vec_t e;
        for (int i = 0; i < tbl_n; i++) begin
            start  = tbl[i].start;
            abort  = tbl[i].abort;
            rounds = tbl[i].rounds;
            sb_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("%s_ready[%0d]", tag, i + 1), 32'(ready), 32'(e.ready));
            chk($sformatf("%s_busy[%0d]", tag, i + 1), 32'(busy), 32'(e.busy));
            chk($sformatf("%s_done[%0d]", tag, i + 1), 32'(done), 32'(e.done));
            chk($sformatf("%s_exp_init[%0d]", tag, i + 1), 32'(exp_init), 32'(e.ei));
            chk($sformatf("%s_exp_run[%0d]", tag, i + 1), 32'(exp_run), 32'(e.er));
            chk($sformatf("%s_exch_run[%0d]", tag, i + 1), 32'(exchange_run), 32'(e.xr));
            chk($sformatf("%s_shift[%0d]", tag, i + 1), 32'(exchange_shift_d), 32'(e.xs));
            chk($sformatf("%s_opt[%0d]", tag, i + 1), 32'(opt_command), 32'(e.opt));
            chk($sformatf("%s_rc[%0d]", tag, i + 1), 32'(round_cnt), 32'(e.rc));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Two full rounds, then idle cycles with round_cnt held
        build_run(-1, 23);
        apply_table("run2");
`ifdef EXCHANGE_STAT_EN
        chk("xchg_after_run2", xchg_cnt, 32'd2);
`endif

        // start pulsed mid-run must be ignored
        build_run(7, 21);
        apply_table("busy_start");

        // abort in cycle 12, then abort+start together while idle
        build_run(-1, 12);
        tbl[12] = idle_rec(1'b0, 1'b1, 16'd2, 1'b1, 16'd1);
        tbl[13] = idle_rec(1'b1, 1'b1, 16'd2, 1'b1, 16'd1);
        tbl[14] = idle_rec(1'b0, 1'b0, 16'd2, 1'b1, 16'd1);
        tbl[15] = idle_rec(1'b0, 1'b0, 16'd2, 1'b1, 16'd1);
        tbl_n = 16;
        apply_table("abort");

        // rounds=0 goes straight to DONE with no strobes
        tbl[0]       = idle_rec(1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
        tbl[0].ready = 1'b0;
        tbl[0].busy  = 1'b1;
        tbl[0].done  = 1'b1;
        tbl[1]       = idle_rec(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
        tbl[2]       = idle_rec(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
        tbl_n = 3;
        apply_table("zero");

        // Asynchronous reset in the middle of a SHIFT window
        build_run(-1, 8);
        apply_table("pre_rst");
        #2 reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
